seven_seg_scanner: RTL and testbench

Parametrised time-multiplexed driver for common-anode seven-segment banks of 1–8 digits on the 100 MHz board clock. It takes one 4-bit hex nibble, a decimal-point bit and an enable bit per digit, and scans the digits at a fixed slot rate. Each slot has an anti-ghosting blank interval. Brightness is set by 4-bit PWM, leading zeros can be suppressed, and inputs are snapshotted once per frame so digits never tear. It sits between datapath/status registers and the board's anode/cathode pins, replacing single-digit display logic.

---
 rtl/seven_seg_scanner.sv | 151 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 7-segment driver
// with per-slot blanking, PWM brightness, LZ blanking and frame snapshots.
module seven_seg_scanner #(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 25000,
  parameter int BLANK_CYC = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [3:0]            bright,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [2:0]    IDX_MAX = 3'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          pwm_q, pwm_d;
  logic                load_q, load_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dps_q, dps_d;
  logic [DIGITS-1:0]   ens_q, ens_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;

  logic        slot_end, snap, blank, gate, vis;
  logic [31:0] val32;
  logic [7:0]  dp8, en8, sup8;
  logic [3:0]  nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  if (BLANK_CYC == 0) begin : g_noblank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = cnt_q < CW'(BLANK_CYC);
  end

  // Pad shadows to 8 digits so idx can index them directly.
  assign val32 = 32'(val_q);
  assign dp8   = 8'(dps_q);
  assign en8   = 8'(ens_q);
  assign nib   = 4'(val32 >> {idx_q, 2'b00});

  always_comb begin
    logic zero_above;
    sup8       = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      zero_above = zero_above && (val32[4*i +: 4] == 4'h0) && !dp8[i];
      sup8[i]    = lz_en && zero_above && (i != 0);
    end
  end

  always_comb begin
    gate = pwm_q < bright;
    if (bright == 4'd0)  gate = 1'b0;
    if (bright == 4'd15) gate = 1'b1;
  end

  assign vis = !blank && en8[idx_q] && gate && !sup8[idx_q];

  always_comb begin
    slot_end = cnt_q == CNT_MAX;
    snap     = load_q || (slot_end && idx_q == IDX_MAX);
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    pwm_d  = pwm_q + 4'd1;
    load_d = 1'b0;
    val_d  = snap ? value : val_q;
    dps_d  = snap ? dp_in : dps_q;
    ens_d  = snap ? digit_en : ens_q;
    fs_d   = snap;
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (vis) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~dp8[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
      load_q <= 1'b1;
      val_q  <= '0;
      dps_q  <= '0;
      ens_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_d;
      load_q <= load_d;
      val_q  <= val_d;
      dps_q  <= dps_d;
      ens_q  <= ens_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: time-indexed behavioural model plus
// directed and random stimulus for the 4-digit scanner.
module tb_seven_seg_scanner;

  localparam int D  = 4;
  localparam int C  = 20;
  localparam int B  = 4;
  localparam int FR = D * C;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en, bright;
  logic        lz_en;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scanner #(.DIGITS(D), .CLK_DIV(C), .BLANK_CYC(B)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .bright(bright), .lz_en(lz_en),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected {an_n, seg_n, dp_n} for the state p cycles after release.
  function automatic logic [11:0] mdl(input int p, input logic [15:0] v,
      input logic [3:0] d, input logic [3:0] e,
      input logic [3:0] br, input logic lz);
    int slot, dig;
    logic g, sup, on;
    slot = p % C;
    dig  = (p / C) % D;
    g    = (br == 0) ? 1'b0 : (br == 15) ? 1'b1 : ((p % 16) < int'(br));
    sup  = lz && dig != 0 && (v >> (4 * dig)) == 0 && (d >> dig) == 0;
    on   = slot >= B && e[dig] && g && !sup;
    if (!on) return {4'hF, 7'h7F, 1'b1};
    return {~(4'b1 << dig), HEX[4'(v >> (4 * dig))], ~d[dig]};
  endfunction

  int          ncyc = 0;
  int          m_p = 0;
  logic        m_first = 1'b1;
  logic [15:0] m_v = '0;
  logic [3:0]  m_d = '0, m_e = '0;
  logic [11:0] exp_o = {4'hF, 7'h7F, 1'b1};
  logic        exp_fs = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p     <= 0;
      m_first <= 1'b1;
      m_v     <= '0;
      m_d     <= '0;
      m_e     <= '0;
      exp_o   <= {4'hF, 7'h7F, 1'b1};
      exp_fs  <= 1'b0;
      ncyc    <= 0;
    end else begin
      exp_o  <= mdl(m_p, m_v, m_d, m_e, bright, lz_en);
      exp_fs <= m_first || (m_p % FR == FR - 1);
      if (m_first || (m_p % FR == FR - 1)) begin
        m_v <= value;
        m_d <= dp_in;
        m_e <= digit_en;
      end
      m_first <= 1'b0;
      m_p     <= m_p + 1;
      ncyc    <= ncyc + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      n_cmp++;
      if ({an_n, seg_n, dp_n, frame_start} !== {exp_o, exp_fs}) begin
        n_bad++;
        $display("FAIL cycle k=%0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                 ncyc, an_n, seg_n, dp_n, frame_start,
                 exp_o[11:8], exp_o[7:1], exp_o[0], exp_fs);
      end
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_k(input int k);
    while (ncyc < k) tick();
  endtask

  function automatic int next_frame();
    return (ncyc / FR + 1) * FR;
  endfunction

  task automatic count_lows(output int c);
    c = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (an_n != 4'hF) c++;
    end
  endtask

  initial begin
    int f, c;
    value = 16'h1234; dp_in = '0; digit_en = 4'hF;
    bright = 4'd15; lz_en = 1'b0;
    repeat (3) tick();
    lit("reset_out", {an_n, seg_n, dp_n, frame_start}, {4'hF, 7'h7F, 2'b10});
    rst = 1'b0;

    tick();
    lit("fs_first", frame_start, 1);
    lit("dark_first", an_n, 4'hF);
    wait_k(5);
    lit("d0_an", an_n, 4'b1110);
    lit("d0_seg4", seg_n, 7'b0011001);
    wait_k(25);
    lit("d1_an", an_n, 4'b1101);
    lit("d1_seg3", seg_n, 7'b0110000);
    wait_k(80);
    lit("fs_frame2", frame_start, 1);

    wait_k(105);
    value = 16'hABCD;
    wait_k(145);
    lit("tear_an", an_n, 4'b0111);
    lit("tear_seg1", seg_n, 7'b1111001);
    wait_k(160);
    lit("fs_frame3", frame_start, 1);
    wait_k(165);
    lit("new_seg_d", seg_n, 7'b0100001);

    for (int n = 0; n < 16; n++) begin
      value = 16'(n); dp_in = 4'b0001;
      f = next_frame();
      wait_k(f + 5);
      lit($sformatf("hex_%0h", n), seg_n, HEX[n]);
      lit("hex_dp", dp_n, 0);
    end

    value = 16'h0050; dp_in = 4'b0000; lz_en = 1'b1;
    f = next_frame();
    wait_k(f + 5);
    lit("lz_d0", {an_n, seg_n}, {4'b1110, 7'b1000000});
    wait_k(f + 25);
    lit("lz_d1", {an_n, seg_n}, {4'b1101, 7'b0010010});
    wait_k(f + 45);
    lit("lz_d2_dark", an_n, 4'hF);
    wait_k(f + 65);
    lit("lz_d3_dark", an_n, 4'hF);
    dp_in = 4'b1000;
    f = next_frame();
    wait_k(f + 45);
    lit("lz_dp_d2", {an_n, seg_n, dp_n}, {4'b1011, 7'b1000000, 1'b1});
    wait_k(f + 65);
    lit("lz_dp_d3", {an_n, seg_n, dp_n}, {4'b0111, 7'b1000000, 1'b0});

    lz_en = 1'b0;
    f = next_frame();
    wait_k(f);
    bright = 4'd4;
    count_lows(c);
    lit("bright4_lows", c, 16);
    bright = 4'd0;
    count_lows(c);
    lit("bright0_lows", c, 0);
    bright = 4'd15;
    count_lows(c);
    lit("bright15_lows", c, 64);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        bright   = 4'($urandom);
        lz_en    = 1'($urandom);
        if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      end
      tick();
    end

    value = 16'h7E3F; dp_in = 4'b0000; digit_en = 4'hF;
    bright = 4'd15; lz_en = 1'b0;
    f = next_frame();
    wait_k(f + 50);
    lit("pre_rst_an", an_n, 4'b1011);
    #2 rst = 1'b1;
    #1 lit("async_rst", {an_n, seg_n, dp_n, frame_start}, {4'hF, 7'h7F, 2'b10});
    repeat (3) tick();
    rst = 1'b0;
    tick();
    lit("fs_after_rst", frame_start, 1);
    wait_k(5);
    lit("resume_d0", {an_n, seg_n}, {4'b1110, 7'b0001110});
    wait_k(FR + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
